// File: rtl/ysyx_220053_divx.sv
// Multi-cycle restoring radix-2 divider with signed and 32-bit word modes.
// Define YSYX_220053_DIV_FASTPATH_EN to finish divide-by-zero and signed overflow one cycle after accept.
module ysyx_220053_divx #(
    parameter int XLEN    = 64,
    parameter int WORD_OP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            div_valid,
    output logic            div_ready,
    input  logic            div_signed,
    input  logic            div_word,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int CW = $clog2(XLEN);
    localparam bit WORD_EN = (XLEN == 64) && (WORD_OP != 0);
`ifdef YSYX_220053_DIV_FASTPATH_EN
    localparam bit FAST_PATH = 1'b1;
`else
    localparam bit FAST_PATH = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem, quo, dsr, dvd_res;
    logic            word_r, neg_q, neg_r, zero_r, ovf_r;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        logic [XLEN-1:0] v;
        v       = {XLEN{x[31]}};
        v[31:0] = x;
        return v;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] x);
        logic [XLEN-1:0] v;
        v       = '0;
        v[31:0] = x;
        return v;
    endfunction

    assign div_ready = (state == IDLE);
    assign out_valid = (state == DONE);

    // Operand decode at the accept edge
    logic            word_in, a_neg, b_neg, in_zero, in_ovf, in_special;
    logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_val, in_res, quo_init;

    always_comb begin
        word_in = WORD_EN && div_word;
        if (word_in) begin
            a_ext   = div_signed ? sext32(dividend[31:0]) : zext32(dividend[31:0]);
            b_ext   = div_signed ? sext32(divisor[31:0])  : zext32(divisor[31:0]);
            min_val = sext32(32'h8000_0000);
            in_res  = sext32(dividend[31:0]);
        end else begin
            a_ext   = dividend;
            b_ext   = divisor;
            min_val = {1'b1, {(XLEN-1){1'b0}}};
            in_res  = dividend;
        end
        a_neg      = div_signed && a_ext[XLEN-1];
        b_neg      = div_signed && b_ext[XLEN-1];
        a_abs      = a_neg ? -a_ext : a_ext;
        b_abs      = b_neg ? -b_ext : b_ext;
        in_zero    = (b_ext == '0);
        in_ovf     = div_signed && (a_ext == min_val) && (b_ext == '1);
        in_special = in_zero || in_ovf;
        // word magnitudes are left-aligned so the MSB-first shift works for both widths
        quo_init   = word_in ? (a_abs << (XLEN - 32)) : a_abs;
    end

    // One restoring step plus final sign/width fix-up
    logic [XLEN:0]   shifted, diff;
    logic [XLEN-1:0] rem_n, quo_n, q_s, r_s, fin_q, fin_r;
    logic            last;

    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        diff    = shifted - {1'b0, dsr};
        if (!diff[XLEN]) begin
            rem_n = diff[XLEN-1:0];
            quo_n = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_n = shifted[XLEN-1:0];
            quo_n = {quo[XLEN-2:0], 1'b0};
        end
        last = (cnt == (word_r ? CW'(31) : CW'(XLEN-1)));
        q_s  = neg_q ? -quo_n : quo_n;
        r_s  = neg_r ? -rem_n : rem_n;
        if (word_r) begin
            q_s = sext32(q_s[31:0]);
            r_s = sext32(r_s[31:0]);
        end
        if (zero_r) begin
            fin_q = '1;
            fin_r = dvd_res;
        end else if (ovf_r) begin
            fin_q = dvd_res;
            fin_r = '0;
        end else begin
            fin_q = q_s;
            fin_r = r_s;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (div_valid) state_n = (FAST_PATH && in_special) ? DONE : CALC;
            CALC:    if (last) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dsr       <= '0;
            dvd_res   <= '0;
            word_r    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            zero_r    <= 1'b0;
            ovf_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (div_valid) begin
                    cnt     <= '0;
                    rem     <= '0;
                    quo     <= quo_init;
                    dsr     <= b_abs;
                    dvd_res <= in_res;
                    word_r  <= word_in;
                    neg_q   <= a_neg ^ b_neg;
                    neg_r   <= a_neg;
                    zero_r  <= in_zero;
                    ovf_r   <= in_ovf;
                    if (FAST_PATH && in_special) begin
                        quotient  <= in_zero ? '1 : in_res;
                        remainder <= in_zero ? in_res : '0;
                    end
                end
                CALC: begin
                    rem <= rem_n;
                    quo <= quo_n;
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        quotient  <= fin_q;
                        remainder <= fin_r;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_220053_divx.sv
// Randomised and directed bench for ysyx_220053_divx against a plain-arithmetic division model.
module tb_ysyx_220053_divx;
    logic        clk = 1'b0;
    logic        rst, flush, div_valid, div_ready, div_signed, div_word;
    logic [63:0] dividend, divisor, quotient, remainder;
    logic        out_valid, out_ready;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef YSYX_220053_DIV_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    ysyx_220053_divx dut (
        .clk(clk), .rst(rst), .flush(flush),
        .div_valid(div_valid), .div_ready(div_ready),
        .div_signed(div_signed), .div_word(div_word),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // RISC-V style division semantics expressed directly with language operators
    function automatic void ref_div(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w,
                                    output logic [63:0] q, output logic [63:0] r, output logic special);
        logic [31:0] a32, b32, q32, r32;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            special = (b32 == 0) || (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF);
            if (b32 == 0) begin
                q32 = 32'hFFFF_FFFF; r32 = a32;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 0;
            end else if (s) begin
                q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32; r32 = a32 % b32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            special = (b == 0) || (s && a == 64'h8000_0000_0000_0000 && b == '1);
            if (b == 0) begin
                q = '1; r = a;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a; r = 0;
            end else if (s) begin
                q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
            end else begin
                q = a / b; r = a % b;
            end
        end
    endfunction

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w,
                          input int hold, input string tag);
        logic [63:0] eq, er;
        logic        sp;
        int          lat, exp_lat;
        ref_div(a, b, s, w, eq, er, sp);
        exp_lat = (FAST && sp) ? 1 : (w ? 33 : 65);
        @(negedge clk);
        chk({tag, "_ready"}, 64'(div_ready), 64'd1);
        div_valid = 1; dividend = a; divisor = b; div_signed = s; div_word = w; out_ready = 0;
        @(posedge clk); #1;
        // operands must have been captured; scramble them
        div_valid = 0; dividend = {$urandom, $urandom}; divisor = {$urandom, $urandom};
        div_signed = ~s; div_word = ~w;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_v"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_q"}, quotient, eq);
            chk({tag, "_hold_r"}, remainder, er);
        end
        @(negedge clk);
        out_ready = 1;
        div_valid = 1;
        @(posedge clk); #1;
        chk({tag, "_handoff_v"}, 64'(out_valid), 64'd0);
        chk({tag, "_handoff_rdy"}, 64'(div_ready), 64'd1);
        chk({tag, "_keep_q"}, quotient, eq);
        out_ready = 0;
        div_valid = 0;
    endtask

    initial begin
        logic [63:0] a, b;
        int          bad;
        rst = 1; flush = 0; div_valid = 0; div_signed = 0; div_word = 0;
        dividend = 0; divisor = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(div_ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_q", quotient, 64'd0);
        chk("rst_r", remainder, 64'd0);
        @(negedge clk); rst = 0;

        run_op(64'd100, 64'd7, 0, 0, 0, "u100_7");
        run_op(-64'sd7, 64'd2, 1, 0, 0, "s_m7_2");
        run_op(64'd5, 64'd0, 0, 0, 0, "div0");
        run_op(64'h8000_0000_0000_0000, '1, 1, 0, 0, "ovf64");
        run_op(64'h8000_0000, 64'hFFFF_FFFF, 1, 1, 0, "ovf32");
        run_op(64'h1_FFFF_FFFF, 64'd1, 0, 1, 0, "w_u");
        run_op(64'h0000_0000_FFFF_FFF9, 64'd0, 1, 1, 0, "w_div0");
        run_op(64'd1000, 64'd33, 0, 0, 5, "hold5");

        // flush mid-calculation
        @(negedge clk);
        div_valid = 1; dividend = 64'd12345; divisor = 64'd3; div_signed = 0; div_word = 0;
        @(posedge clk); #1;
        div_valid = 0;
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1;
        @(posedge clk); #1;
        flush = 0;
        chk("flush_ready", 64'(div_ready), 64'd1);
        chk("flush_valid", 64'(out_valid), 64'd0);
        bad = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid) bad++;
        end
        chk("flush_no_result", 64'(bad), 64'd0);

        // reset mid-calculation discards the operation and clears results
        @(negedge clk);
        div_valid = 1; dividend = 64'd999; divisor = 64'd4;
        @(posedge clk); #1;
        div_valid = 0;
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("rstcalc_ready", 64'(div_ready), 64'd1);
        chk("rstcalc_q", quotient, 64'd0);
        chk("rstcalc_r", remainder, 64'd0);

        for (int k = 0; k < 40; k++) begin
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: b = 64'd0;
                1: b = 64'($urandom_range(1, 20));
                2: b = {$urandom, $urandom};
                default: b = {32'd0, $urandom} >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 7) == 0) b = '1;
            if ($urandom_range(0, 1) == 0) b = -b;
            run_op(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), $sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
